// File: rtl/iob_onehot_dec_pkg.sv
// Shared constants and helpers for the one-hot decoder slice.
package iob_onehot_dec_pkg;

  localparam int DEF_W = 21;

  function automatic bit is_pow2(int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/iob_onehot_dec_if.sv
// Handshake bundle around the decoder: index in, one-hot/err out.
interface iob_onehot_dec_if
  import iob_onehot_dec_pkg::*;
#(
  parameter int W = DEF_W,
  localparam int IW = $clog2(W)
);
  logic [IW-1:0] enc;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  onehot;
  logic          err;
  logic          out_valid;
  logic          out_ready;

  modport master (output enc, in_valid, out_ready, input in_ready, onehot, err, out_valid);
  modport slave  (input enc, in_valid, out_ready, output in_ready, onehot, err, out_valid);
endinterface

// File: rtl/iob_bin2onehot.sv
// Combinational index-to-one-hot; err flags indices that have no output bit.
module iob_bin2onehot #(
  parameter int W = 21,
  localparam int IW = $clog2(W)
) (
  input  logic [IW-1:0] enc_i,
  output logic [W-1:0]  onehot_o,
  output logic          err_o
);

  always_comb begin
    onehot_o = '0;
    err_o    = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (enc_i == IW'(i)) begin
        onehot_o[i] = 1'b1;
        err_o       = 1'b0;
      end
    end
  end

endmodule

// File: rtl/iob_reg.sv
// Async-reset, clock-enabled register primitive.
module iob_reg #(
  parameter int            DW      = 1,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic          clk_i,
  input  logic          arst_n_i,
  input  logic          cke_i,
  input  logic          en_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)          q_o <= RST_VAL;
    else if (cke_i && en_i) q_o <= d_i;
  end

endmodule

// File: rtl/iob_onehot_dec.sv
// Index-to-one-hot decoder behind a 2-entry skid buffer; ready_o is registered
// so upstream never sees a combinational path from ready_i.
module iob_onehot_dec
  import iob_onehot_dec_pkg::*;
#(
  parameter int W = DEF_W,
  localparam int IW = $clog2(W)
) (
  input  logic          clk_i,
  input  logic          arst_n_i,
  input  logic          cke_i,
  input  logic [IW-1:0] enc_i,
  input  logic          valid_i,
  output logic          ready_o,
  output logic [W-1:0]  onehot_o,
  output logic          err_o,
  output logic          valid_o,
  input  logic          ready_i
);

  localparam logic [1:0] EMPTY_ENC = 2'd0;
  localparam logic [1:0] ONE_ENC   = 2'd1;
  localparam logic [1:0] FULL_ENC  = 2'd2;

  typedef enum logic [1:0] {EMPTY = EMPTY_ENC, ONE = ONE_ENC, FULL = FULL_ENC} state_t;

  state_t       state;
  logic         in_xfer, out_xfer;
  logic [W-1:0] dec_onehot;
  logic         dec_err;
  logic [W:0]   dec_d, out_d, out_q, skid_q;
  logic         out_en, skid_en;

  assign in_xfer  = valid_i && ready_o && cke_i;
  assign out_xfer = valid_o && ready_i && cke_i;

  // Decode at the input so both buffer entries hold ready-to-present data.
  iob_bin2onehot #(.W(W)) u_dec (
    .enc_i    (enc_i),
    .onehot_o (dec_onehot),
    .err_o    (dec_err)
  );

  assign dec_d = {dec_err, dec_onehot};

  always_comb begin
    out_en  = 1'b0;
    skid_en = 1'b0;
    out_d   = dec_d;
    case (state)
      EMPTY: out_en = in_xfer;
      ONE: begin
        out_en  = in_xfer && out_xfer;
        skid_en = in_xfer && !out_xfer;
      end
      FULL: begin
        out_en = out_xfer;
        out_d  = skid_q;
      end
      default: ;
    endcase
  end

  iob_reg #(.DW(W + 1)) u_out_reg (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .cke_i    (cke_i),
    .en_i     (out_en),
    .d_i      (out_d),
    .q_o      (out_q)
  );

  iob_reg #(.DW(W + 1)) u_skid_reg (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .cke_i    (cke_i),
    .en_i     (skid_en),
    .d_i      (dec_d),
    .q_o      (skid_q)
  );

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state   <= EMPTY;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
    end else if (cke_i) begin
      case (state)
        EMPTY: if (in_xfer) begin
          state   <= ONE;
          valid_o <= 1'b1;
        end
        ONE: begin
          if (in_xfer && !out_xfer) begin
            state   <= FULL;
            ready_o <= 1'b0;
          end else if (!in_xfer && out_xfer) begin
            state   <= EMPTY;
            valid_o <= 1'b0;
          end
        end
        FULL: if (out_xfer) begin
          state   <= ONE;
          ready_o <= 1'b1;
        end
        default: begin
          state   <= EMPTY;
          ready_o <= 1'b1;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

  assign onehot_o = out_q[W-1:0];
  // Every index is in range for power-of-two widths.
  assign err_o    = is_pow2(W) ? 1'b0 : out_q[W];

endmodule

// File: tb/tb_iob_onehot_dec.sv
// Bench for iob_onehot_dec (W=21): vector table, corner sequences, random scoreboard.
module tb_iob_onehot_dec;
  localparam int W  = 21;
  localparam int IW = $clog2(W);

  logic clk = 1'b0;
  logic arst_n;
  logic cke;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  iob_onehot_dec_if #(.W(W)) bus ();

  iob_onehot_dec #(.W(W)) dut (
    .clk_i    (clk),
    .arst_n_i (arst_n),
    .cke_i    (cke),
    .enc_i    (bus.enc),
    .valid_i  (bus.in_valid),
    .ready_o  (bus.in_ready),
    .onehot_o (bus.onehot),
    .err_o    (bus.err),
    .valid_o  (bus.out_valid),
    .ready_i  (bus.out_ready)
  );

  typedef struct {
    int          enc;
    logic [20:0] onehot;
    logic        err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: bit e set when in range, else error with an empty vector.
  function automatic logic [21:0] ref_dec(int e);
    if (e < W) return 22'(64'd1 << e);
    return 22'h200000;
  endfunction

  function automatic logic [21:0] dut_out();
    return {bus.err, bus.onehot};
  endfunction

  logic [21:0] exp_q[$];

  initial begin
    vecs[0] = '{5,  21'h000020, 1'b0};
    vecs[1] = '{25, 21'h000000, 1'b1};
    vecs[2] = '{20, 21'h100000, 1'b0};
    vecs[3] = '{0,  21'h000001, 1'b0};
    vecs[4] = '{21, 21'h000000, 1'b1};
    vecs[5] = '{31, 21'h000000, 1'b1};
    vecs[6] = '{10, 21'h000400, 1'b0};
    vecs[7] = '{1,  21'h000002, 1'b0};

    arst_n = 1'b0; cke = 1'b1;
    bus.enc = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick(); tick();
    chk("reset valid_o", 32'(bus.out_valid), 32'd0);
    chk("reset ready_o", 32'(bus.in_ready), 32'd1);
    chk("reset onehot_o", 32'(bus.onehot), 32'd0);
    chk("reset err_o", 32'(bus.err), 32'd0);
    arst_n = 1'b1;
    tick();

    // Table-driven single decodes.
    foreach (vecs[i]) begin
      bus.enc = IW'(vecs[i].enc); bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      chk($sformatf("vec%0d valid_o", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("vec%0d onehot_o", i), 32'(bus.onehot), 32'(vecs[i].onehot));
      chk($sformatf("vec%0d err_o", i), 32'(bus.err), 32'(vecs[i].err));
      tick();
      chk($sformatf("vec%0d valid_o drop", i), 32'(bus.out_valid), 32'd0);
    end

    // Backpressure: fill both entries, third item held off.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.enc = 5'd0;
    tick();
    chk("bp ready after 1st", 32'(bus.in_ready), 32'd1);
    bus.enc = 5'd1;
    tick();
    chk("bp ready after 2nd", 32'(bus.in_ready), 32'd0);
    bus.enc = 5'd2;
    tick();
    chk("bp ready held", 32'(bus.in_ready), 32'd0);
    chk("bp onehot stable", 32'(bus.onehot), 32'h1);
    tick();
    chk("bp onehot stable2", 32'(bus.onehot), 32'h1);
    chk("bp valid held", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    tick();
    chk("bp out 2nd", 32'(bus.onehot), 32'h2);
    chk("bp ready back", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("bp out 3rd", 32'(bus.onehot), 32'h4);
    tick();
    chk("bp drained", 32'(bus.out_valid), 32'd0);

    // Clock enable low: no transfer, state holds.
    cke = 1'b0; bus.in_valid = 1'b1; bus.enc = 5'd3;
    tick(); tick();
    chk("cke0 no accept", 32'(bus.out_valid), 32'd0);
    cke = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("cke1 accept", 32'(bus.onehot), 32'h8);
    cke = 1'b0;
    tick();
    chk("cke0 hold output", 32'(bus.out_valid), 32'd1);
    cke = 1'b1;
    tick();
    chk("cke1 drain", 32'(bus.out_valid), 32'd0);

    // Throughput with random indices against the queue model.
    begin
      int sent = 0, recv = 0, cyc = 0, e = 0;
      bit in_acc, out_acc;
      bus.out_ready = 1'b1;
      while (recv < 100 && cyc < 300) begin
        if (sent < 100) begin
          e = int'($urandom_range(0, 31));
          bus.enc = IW'(e); bus.in_valid = 1'b1;
        end else begin
          bus.in_valid = 1'b0;
        end
        #0;
        in_acc  = bus.in_valid && bus.in_ready;
        out_acc = bus.out_valid && bus.out_ready;
        if (out_acc) begin
          if (exp_q.size() == 0) chk("tp unexpected output", 32'(dut_out()), 32'hFFFFFFFF);
          else chk($sformatf("tp item%0d", recv), 32'(dut_out()), 32'(exp_q.pop_front()));
          recv++;
        end
        tick();
        cyc++;
        if (in_acc) begin
          exp_q.push_back(ref_dec(e));
          sent++;
        end
      end
      bus.in_valid = 1'b0;
      chk("tp received", 32'(recv), 32'd100);
      chk("tp cycles", 32'(cyc), 32'd101);
      chk("tp queue empty", 32'(exp_q.size()), 32'd0);
    end

    // Reset while FULL discards both entries immediately.
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.enc = 5'd7;
    tick();
    bus.enc = 5'd8;
    tick();
    bus.in_valid = 1'b0;
    chk("full ready_o", 32'(bus.in_ready), 32'd0);
    arst_n = 1'b0;
    #1;
    chk("rstfull valid_o", 32'(bus.out_valid), 32'd0);
    chk("rstfull ready_o", 32'(bus.in_ready), 32'd1);
    chk("rstfull onehot_o", 32'(bus.onehot), 32'd0);
    tick();
    arst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    chk("post-rst no stale", 32'(bus.out_valid), 32'd0);
    tick();
    chk("post-rst no stale2", 32'(bus.out_valid), 32'd0);
    bus.enc = 5'd9; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("post-rst decode", 32'(dut_out()), 32'(ref_dec(9)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iob_onehot_dec.md
IOB_ONEHOT_DEC -- requirements
Module: iob_onehot_dec

Interface
REQ-001 Parameter W, default 21: one-hot output width; W >= 2.
REQ-002 Local constant IW = $clog2(W): index width.
REQ-003 clk_i  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 arst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 cke_i  input  1  clock enable; when 0, all state SHALL hold.
REQ-006 enc_i  input  IW  binary index to decode.
REQ-007 valid_i  input  1  enc_i valid.
REQ-008 ready_o  output  1  block can accept enc_i.
REQ-009 onehot_o  output  W  decoded one-hot vector.
REQ-010 err_o  output  1  index out of range (enc_i >= W).
REQ-011 valid_o  output  1  onehot_o/err_o valid.
REQ-012 ready_i  input  1  downstream accepts output.

Function
REQ-013 Input transfer SHALL occur when valid_i && ready_o && cke_i; output transfer SHALL occur when valid_o && ready_i && cke_i.
REQ-014 Decode: onehot_o SHALL have only bit enc_i set and err_o=0 when enc_i < W; onehot_o SHALL be all zero and err_o=1 when enc_i >= W.
REQ-015 Latency: a transfer accepted in cycle N into an empty block SHALL appear on valid_o in cycle N+1.
REQ-016 Buffering SHALL be a 2-entry skid buffer: output register plus skid register, both holding decoded {onehot, err}.
REQ-017 FSM states: EMPTY (no data), ONE (output reg valid), FULL (output and skid valid).
REQ-018 EMPTY: input transfer -> ONE; otherwise stay.
REQ-019 ONE: input and output transfer together -> ONE with output reg reloaded; input only -> FULL with data in skid; output only -> EMPTY; neither -> stay.
REQ-020 FULL: output transfer -> ONE with skid moved to output reg; otherwise stay; no input accepted.
REQ-021 ready_o SHALL be registered and equal 1 exactly in EMPTY and ONE; it SHALL not depend combinationally on ready_i.
REQ-022 valid_o SHALL be 1 exactly in ONE and FULL; onehot_o/err_o SHALL be stable while valid_o=1 and ready_i=0.
REQ-023 Ordering SHALL be strict FIFO; no item SHALL be dropped or duplicated.
REQ-024 Sustained valid_i=1, ready_i=1 SHALL give one transfer per cycle.
REQ-025 When cke_i=0, no transfer SHALL occur regardless of valid/ready.
REQ-026 When W is a power of two, err_o SHALL be constant 0.

Reset
REQ-027 On arst_n_i=0, state SHALL become EMPTY immediately: valid_o=0, ready_o=1, onehot_o=0, err_o=0, skid register=0.
REQ-028 Reset mid-operation SHALL discard buffered data; first cycle after release behaves as EMPTY.
REQ-029 Reset deassertion SHALL be assumed synchronised externally; no in-block synchroniser.

Structure
REQ-030 FSM state encodings (EMPTY/ONE/FULL) SHALL be localparams in the module; no shared package needed.
REQ-031 The combinational index-to-one-hot function SHALL be one sub-module iob_bin2onehot (parameter W), instantiated once at the input side.
REQ-032 Data registers SHALL use the codebase's standard async-reset, clock-enabled register primitive.

Verification (W=21)
REQ-033 Reset: hold arst_n_i=0, pulse clk -> valid_o=0, ready_o=1, onehot_o=0, err_o=0.
REQ-034 Single decode: enc_i=5, valid_i=1 one cycle, ready_i=1 -> next cycle valid_o=1, onehot_o=21'h000020, err_o=0, then valid_o=0.
REQ-035 Out of range: enc_i=25 -> onehot_o=0, err_o=1; enc_i=20 -> onehot_o=21'h100000, err_o=0.
REQ-036 Backpressure: ready_i=0, send 0,1,2 back-to-back -> ready_o falls after second accept, third held; release ready_i -> outputs 21'h1, 21'h2, 21'h4 in order, none lost.
REQ-037 Throughput: 100 random indices, valid_i=ready_i=1 -> 100 outputs in 101 cycles, matching scoreboard.
REQ-038 Reset in FULL: assert arst_n_i with two items buffered -> immediately valid_o=0, ready_o=1; no stale output after release.
